// File: rtl/seq_mag_comparator.sv
// seq_mag_comparator
//   Multi-cycle magnitude comparator. It compares two WIDTH-bit operands
//   MSB-first, CHUNK bits per clock, and stops at the first chunk that
//   differs. Each operation selects signed (two's complement) or unsigned
//   mode.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high; abandons any running compare
//   start        request a compare; sampled only while busy=0
//   signed_mode  1 = two's-complement compare; captured with start
//   A, B         operands; captured with start
//   busy         a compare is in progress
//   done         one-cycle pulse when the result flags update
//   AgtB/AltB/AeqB  registered result flags; all zero means "no valid result"
module seq_mag_comparator #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             AgtB,
    output logic             AltB,
    output logic             AeqB
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] IDX_MSB = IW'(NCHUNK - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CMP  = 1'b1;

    generate
        if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
            $error("seq_mag_comparator: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    logic [0:0]       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sm_q, sm_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;

    logic [CHUNK-1:0] ca, cb;
    logic             sign_split;

    assign ca = a_q[int'(idx_q)*CHUNK +: CHUNK];
    assign cb = b_q[int'(idx_q)*CHUNK +: CHUNK];

    // On the MSB chunk in signed mode, differing sign bits settle the result.
    // With equal sign bits, unsigned chunk order matches two's-complement order.
    assign sign_split = sm_q && (idx_q == IDX_MSB) && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sm_d    = sm_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    sm_d    = signed_mode;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    busy_d  = 1'b1;
                    idx_d   = IDX_MSB;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                if (sign_split || (ca != cb) || (idx_q == '0)) begin
                    // The result is known this cycle.
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                    if (sign_split) begin
                        gt_d = b_q[WIDTH-1];
                        lt_d = a_q[WIDTH-1];
                    end else if (ca != cb) begin
                        gt_d = (ca > cb);
                        lt_d = (ca < cb);
                    end else begin
                        eq_d = 1'b1;
                    end
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sm_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sm_q    <= sm_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign AgtB = gt_q;
    assign AltB = lt_q;
    assign AeqB = eq_q;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Testbench for seq_mag_comparator. It uses two instances, WIDTH=8/CHUNK=2
// and WIDTH=12/CHUNK=4. Each accepted start pushes an expected record into a
// per-instance queue. A monitor pops a record on every done and compares the
// flags and the latency.
module tb_seq_mag_comparator;
    typedef struct {
        logic gt, lt, eq;
        int   lat;
        int   t0;
    } exp_t;

    typedef struct {
        logic [7:0] a, b;
        logic       sm;
        logic       gt, lt, eq;
        int         lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        s0 = 0, sm0 = 0, busy0, done0, gt0, lt0, eq0;
    logic [7:0]  a0 = '0, b0 = '0;
    logic        s1 = 0, sm1 = 0, busy1, done1, gt1, lt1, eq1;
    logic [11:0] a1 = '0, b1 = '0;

    seq_mag_comparator #(.WIDTH(8), .CHUNK(2)) dut0 (
        .clk(clk), .rst(rst), .start(s0), .signed_mode(sm0), .A(a0), .B(b0),
        .busy(busy0), .done(done0), .AgtB(gt0), .AltB(lt0), .AeqB(eq0));

    seq_mag_comparator #(.WIDTH(12), .CHUNK(4)) dut1 (
        .clk(clk), .rst(rst), .start(s1), .signed_mode(sm1), .A(a1), .B(b1),
        .busy(busy1), .done(done1), .AgtB(gt1), .AltB(lt1), .AeqB(eq1));

    int n_chk = 0, n_pass = 0;
    exp_t q0[$], q1[$];

    task automatic chk(input string nm, input longint act, input longint req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    endtask

    // Reference: full-width integer compare, plus a scan for the first differing chunk.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic sm, input int w, input int c);
        exp_t   e;
        longint va, vb;
        logic [31:0] m, cm;
        int n;
        n  = w / c;
        m  = (32'h1 << w) - 1;
        cm = (32'h1 << c) - 1;
        va = longint'(a & m);
        vb = longint'(b & m);
        if (sm && a[w-1]) va = va - (64'sd1 <<< w);
        if (sm && b[w-1]) vb = vb - (64'sd1 <<< w);
        e.gt = (va > vb);
        e.lt = (va < vb);
        e.eq = (va == vb);
        e.lat = n;
        e.t0 = 0;
        for (int i = n - 1; i >= 0; i--) begin
            if (((a >> (i * c)) & cm) != ((b >> (i * c)) & cm)) begin
                e.lat = n - i;
                break;
            end
        end
        return e;
    endfunction

    // Monitors: the result and latency of every done pulse.
    always @(negedge clk) begin
        if (done0) begin
            chk("dut0_done_expected", q0.size() != 0, 1);
            if (q0.size() != 0) begin
                exp_t e;
                e = q0.pop_front();
                chk("dut0_flags", {gt0, lt0, eq0}, {e.gt, e.lt, e.eq});
                chk("dut0_latency", cyc - e.t0, e.lat);
            end
        end
        if (done1) begin
            chk("dut1_done_expected", q1.size() != 0, 1);
            if (q1.size() != 0) begin
                exp_t e;
                e = q1.pop_front();
                chk("dut1_flags", {gt1, lt1, eq1}, {e.gt, e.lt, e.eq});
                chk("dut1_latency", cyc - e.t0, e.lat);
            end
        end
    end

    // Called at a negedge. Waits, with a cycle budget, until the instance is idle.
    task automatic wait_idle(input int d);
        int k = 0;
        while ((d == 0) ? busy0 : busy1) begin
            @(negedge clk);
            k++;
            if (k > 100) begin
                n_chk++;
                $display("FAIL idle_timeout dut%0d: busy still 1 after %0d cycles", d, k);
                return;
            end
        end
    endtask

    // Called at a negedge while the instance is idle. Pulses start for one edge,
    // queues the expected record, and returns at the following negedge.
    task automatic issue(input int d, input logic [31:0] a, input logic [31:0] b,
                         input logic sm, input exp_t e);
        if (d == 0) begin a0 = a[7:0]; b0 = b[7:0]; sm0 = sm; s0 = 1; end
        else begin a1 = a[11:0]; b1 = b[11:0]; sm1 = sm; s1 = 1; end
        @(posedge clk);
        #1;
        e.t0 = cyc;
        if (d == 0) begin q0.push_back(e); s0 = 0; end
        else begin q1.push_back(e); s1 = 0; end
        @(negedge clk);
    endtask

    function automatic exp_t mk(input logic gt, input logic lt, input logic eq, input int lat);
        exp_t e;
        e.gt = gt; e.lt = lt; e.eq = eq; e.lat = lat; e.t0 = 0;
        return e;
    endfunction

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        tbl[1]  = '{8'hF0, 8'h05, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        tbl[2]  = '{8'hF0, 8'h05, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[3]  = '{8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[4]  = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        tbl[5]  = '{8'h7F, 8'h7E, 1'b0, 1'b1, 1'b0, 1'b0, 4};
        tbl[6]  = '{8'hFF, 8'hFE, 1'b1, 1'b1, 1'b0, 1'b0, 4};
        tbl[7]  = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 4};
        tbl[8]  = '{8'h40, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        tbl[9]  = '{8'h0C, 8'h08, 1'b0, 1'b1, 1'b0, 1'b0, 3};
        tbl[10] = '{8'hFE, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 4};
        tbl[11] = '{8'h01, 8'h81, 1'b1, 1'b1, 1'b0, 1'b0, 1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs0", {busy0, done0, gt0, lt0, eq0}, 0);
        chk("rst_outputs1", {busy1, done1, gt1, lt1, eq1}, 0);
        rst = 0;
        @(negedge clk);

        // Table vectors
        foreach (tbl[i]) begin
            wait_idle(0);
            issue(0, tbl[i].a, tbl[i].b, tbl[i].sm,
                  mk(tbl[i].gt, tbl[i].lt, tbl[i].eq, tbl[i].lat));
        end
        wait_idle(0);
        @(negedge clk);

        // Equal operands: flags stay clear while busy and hold after done
        issue(0, 8'hA5, 8'hA5, 1'b0, mk(0, 0, 1, 4));
        chk("eq_busy_flags", {busy0, gt0, lt0, eq0}, 4'b1000);
        wait_idle(0);
        repeat (3) @(negedge clk);
        chk("eq_hold_flags", {done0, gt0, lt0, eq0}, 4'b0001);
        issue(0, 8'hA5, 8'hA5, 1'b1, mk(0, 0, 1, 4));
        chk("eq_cleared_on_start", eq0, 0);
        wait_idle(0);
        @(negedge clk);

        // Start while busy is ignored
        issue(0, 8'h01, 8'h02, 1'b0, mk(0, 1, 0, 4));
        a0 = 8'hFF; b0 = 8'h00; sm0 = 1; s0 = 1;
        @(negedge clk);
        s0 = 0;
        wait_idle(0);
        repeat (4) @(negedge clk);
        chk("ignored_start_flags", {busy0, gt0, lt0, eq0}, 4'b0010);

        // Reset abandons a running compare
        issue(0, 8'h55, 8'h55, 1'b0, mk(0, 0, 1, 4));
        rst = 1;
        @(negedge clk);
        rst = 0;
        q0.delete();
        chk("rst_abort_outputs", {busy0, done0, gt0, lt0, eq0}, 0);
        repeat (6) @(negedge clk);
        chk("rst_abort_quiet", {busy0, gt0, lt0, eq0}, 0);
        issue(0, 8'h80, 8'h7F, 1'b0, mk(1, 0, 0, 1));
        wait_idle(0);
        @(negedge clk);

        // start held high: each done is followed by acceptance on the next edge
        begin
            logic [7:0] ha[3], hb[3];
            ha = '{8'h33, 8'hC0, 8'h9A};
            hb = '{8'h31, 8'h10, 8'h9A};
            for (int i = 0; i < 3; i++) begin
                exp_t e;
                e = model(32'(ha[i]), 32'(hb[i]), 1'b1, 8, 2);
                a0 = ha[i]; b0 = hb[i]; sm0 = 1; s0 = 1;
                @(posedge clk);
                #1;
                e.t0 = cyc;
                q0.push_back(e);
                if (i == 2) s0 = 0;
                @(negedge clk);
                chk("held_start_accept", busy0, 1);
                if (i < 2) begin
                    int k = 0;
                    while (!done0 && k < 20) begin @(negedge clk); k++; end
                    chk("held_done_seen", done0, 1);
                end
            end
            wait_idle(0);
            @(negedge clk);
        end

        // Random sweep on both configurations
        for (int d = 0; d < 2; d++) begin
            int w, c;
            w = (d == 0) ? 8 : 12;
            c = (d == 0) ? 2 : 4;
            for (int n = 0; n < 500; n++) begin
                logic [31:0] a, b, m;
                logic        sm;
                m  = (32'h1 << w) - 1;
                a  = $urandom & m;
                case ($urandom_range(0, 3))
                    0, 1: b = $urandom & m;
                    2:    b = a ^ (32'h1 << $urandom_range(0, w - 1));
                    default: b = a;
                endcase
                sm = 1'($urandom_range(0, 1));
                wait_idle(d);
                issue(d, a, b, sm, model(a, b, sm, w, c));
            end
            wait_idle(d);
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("dut0_queue_drained", q0.size(), 0);
        chk("dut1_queue_drained", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
